// File: rtl/pipe_hazard_unit_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_unit_if
//   Decode-side bundle between the decode stage and the hazard/pipeline-control
//   unit. Decode is the master: it presents the candidate instruction's register
//   usage and class plus the interrupt inputs. The hazard unit is the slave: it
//   returns the issue decision, the stall/flush controls and the interrupt take.
//
//   Parameters:
//     N_BACK : back-end stages tracked after decode (2..8)
//     RA_W   : register-address width
//
//   Signals (master -> slave):
//     de_v, de_sr1, de_sr2, de_sr1_use, de_sr2_use, de_dr, de_dr_wen,
//     de_ctrl, de_trap, ie, interrupt
//   Signals (slave -> master):
//     de_issue, v_dep_stall, v_br_stall, v_trap_stall, flush, int_taken, occ
// ---------------------------------------------------------------------------
interface pipe_hazard_unit_if #(
  parameter int N_BACK = 3,
  parameter int RA_W   = 5
);
  localparam int OCC_W = $clog2(N_BACK + 1);

  logic            de_v;
  logic [RA_W-1:0] de_sr1;
  logic [RA_W-1:0] de_sr2;
  logic            de_sr1_use;
  logic            de_sr2_use;
  logic [RA_W-1:0] de_dr;
  logic            de_dr_wen;
  logic            de_ctrl;
  logic            de_trap;
  logic            ie;
  logic            interrupt;

  logic             de_issue;
  logic             v_dep_stall;
  logic             v_br_stall;
  logic             v_trap_stall;
  logic             flush;
  logic             int_taken;
  logic [OCC_W-1:0] occ;

  modport master (
    output de_v, de_sr1, de_sr2, de_sr1_use, de_sr2_use, de_dr, de_dr_wen,
           de_ctrl, de_trap, ie, interrupt,
    input  de_issue, v_dep_stall, v_br_stall, v_trap_stall, flush,
           int_taken, occ
  );

  modport slave (
    input  de_v, de_sr1, de_sr2, de_sr1_use, de_sr2_use, de_dr, de_dr_wen,
           de_ctrl, de_trap, ie, interrupt,
    output de_issue, v_dep_stall, v_br_stall, v_trap_stall, flush,
           int_taken, occ
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// ---------------------------------------------------------------------------
// pipe_hazard_unit
//   Hazard and pipeline-control unit for the in-order core. A shadow shift
//   register (one entry per back-end stage, entry 0 = EXE, entry N_BACK-1 =
//   final stage) mirrors every in-flight instruction. From it the unit derives
//   RAW dependency stalls, branch and trap fetch stalls, the global flush, and
//   a drained-pipeline interrupt take.
//
//   Ports:
//     clk   : core clock
//     reset : synchronous, active-high reset
//     bus   : pipe_hazard_unit_if.slave (decode inputs, control outputs)
//
//   Build option:
//     PIPE_HAZARD_WB_BYPASS_EN : when defined, the final-stage entry is left
//       out of the dependency check because the register file writes before
//       it reads; when undefined, a consumer waits until its producer retires.
// ---------------------------------------------------------------------------
module pipe_hazard_unit #(
  parameter int N_BACK = 3,
  parameter int RA_W   = 5
) (
  input logic             clk,
  input logic             reset,
  pipe_hazard_unit_if.slave bus
);

  localparam int OCC_W = $clog2(N_BACK + 1);
`ifdef PIPE_HAZARD_WB_BYPASS_EN
  localparam int N_CHK = N_BACK - 1;
`else
  localparam int N_CHK = N_BACK;
`endif

  typedef enum logic [1:0] {
    INT_IDLE,
    INT_PEND,
    INT_TAKE,
    INT_WAIT
  } int_state_t;

  logic [N_BACK-1:0] ent_v;
  logic [N_BACK-1:0] ent_wen;
  logic [N_BACK-1:0] ent_ctrl;
  logic [N_BACK-1:0] ent_trap;
  logic [RA_W-1:0]   ent_dr [N_BACK];

  int_state_t int_state;
  int_state_t int_state_nxt;

  logic             dep_hit;
  logic             br_any;
  logic             trap_any;
  logic             flush;
  logic             int_block;
  logic             issue;
  logic [OCC_W-1:0] occ_cnt;

  // Scan the tracker. Occupancy and the ctrl/trap summaries look at every
  // stage; the RAW check only at the stages that cannot yet forward through
  // the register file. Invalid entries never contribute, so the don't-care
  // fields loaded alongside a bubble are harmless. Register x0 and unused
  // sources are excluded because they can never carry a real dependency.
  always_comb begin
    dep_hit  = 1'b0;
    br_any   = 1'b0;
    trap_any = 1'b0;
    occ_cnt  = '0;
    for (int i = 0; i < N_BACK; i++) begin
      if (ent_v[i]) begin
        occ_cnt = occ_cnt + OCC_W'(1);
        if (ent_ctrl[i]) br_any = 1'b1;
        if (ent_trap[i]) trap_any = 1'b1;
      end
    end
    for (int i = 0; i < N_CHK; i++) begin
      if (ent_v[i] && ent_wen[i]) begin
        if (bus.de_sr1_use && (bus.de_sr1 != '0) && (ent_dr[i] == bus.de_sr1))
          dep_hit = 1'b1;
        if (bus.de_sr2_use && (bus.de_sr2 != '0) && (ent_dr[i] == bus.de_sr2))
          dep_hit = 1'b1;
      end
    end
  end

  // A trap reaching the final stage flushes everything younger. The interrupt
  // blocks issue from the moment the request is seen (so nothing new slips in
  // while the FSM moves to PEND) until the take cycle itself, after which the
  // handler's instructions are free to issue.
  always_comb begin
    flush     = ent_v[N_BACK-1] & ent_trap[N_BACK-1];
    int_block = bus.ie & (((int_state == INT_IDLE) & bus.interrupt) |
                          (int_state == INT_PEND) |
                          (int_state == INT_TAKE));
    issue     = bus.de_v & ~dep_hit & ~flush & ~int_block;
  end

  assign bus.de_issue     = issue;
  assign bus.v_dep_stall  = bus.de_v & dep_hit;
  assign bus.v_br_stall   = (bus.de_v & bus.de_ctrl) | br_any;
  assign bus.v_trap_stall = (bus.de_v & bus.de_trap) | trap_any;
  assign bus.flush        = flush;
  assign bus.int_taken    = (int_state == INT_TAKE);
  assign bus.occ          = occ_cnt;

  // The back end never stalls, so the tracker shifts every cycle. Entry 0
  // takes whatever decode presents, with its valid bit gated by the issue
  // decision. A flush clears every valid bit; the retiring trap is leaving
  // anyway and the issue gate already forces a bubble into entry 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_v    <= '0;
      ent_wen  <= '0;
      ent_ctrl <= '0;
      ent_trap <= '0;
      for (int i = 0; i < N_BACK; i++) ent_dr[i] <= '0;
    end else begin
      ent_v    <= flush ? '0 : {ent_v[N_BACK-2:0], issue};
      ent_wen  <= {ent_wen[N_BACK-2:0], bus.de_dr_wen};
      ent_ctrl <= {ent_ctrl[N_BACK-2:0], bus.de_ctrl};
      ent_trap <= {ent_trap[N_BACK-2:0], bus.de_trap};
      ent_dr[0] <= bus.de_dr;
      for (int i = 1; i < N_BACK; i++) ent_dr[i] <= ent_dr[i-1];
    end
  end

  // Interrupt state register; reset drops any pending request.
  always_ff @(posedge clk) begin
    if (reset) int_state <= INT_IDLE;
    else       int_state <= int_state_nxt;
  end

  // Interrupt sequencing: wait for the pipeline to drain, pulse once, then
  // wait for the request level to fall so a held request is taken only once.
  // A flush in the drain cycle defers the take; PEND simply holds.
  always_comb begin
    int_state_nxt = int_state;
    case (int_state)
      INT_IDLE: if (bus.interrupt && bus.ie) int_state_nxt = INT_PEND;
      INT_PEND: begin
        if (!bus.ie)                             int_state_nxt = INT_IDLE;
        else if ((occ_cnt == '0) && !flush)      int_state_nxt = INT_TAKE;
      end
      INT_TAKE: int_state_nxt = INT_WAIT;
      INT_WAIT: if (!bus.interrupt) int_state_nxt = INT_IDLE;
      default:  int_state_nxt = INT_IDLE;
    endcase
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_unit
//   Self-checking bench for pipe_hazard_unit. A reference model keeps a list of
//   issued instructions stamped with their issue cycle and derives every output
//   from instruction age; it is compared against the DUT each cycle. Directed
//   scenarios pin the model with literal expectations, then randomized traffic
//   runs against it.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_unit;

  localparam int N_BACK = 3;
  localparam int RA_W   = 5;
`ifdef PIPE_HAZARD_WB_BYPASS_EN
  localparam int CHK_AGE = N_BACK - 1;
`else
  localparam int CHK_AGE = N_BACK;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;

  pipe_hazard_unit_if #(.N_BACK(N_BACK), .RA_W(RA_W)) bus ();

  pipe_hazard_unit #(.N_BACK(N_BACK), .RA_W(RA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running core clock.
  always #5 clk = ~clk;

  // Runaway guard in case a scenario never completes.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input int rst, input int ie, input int intr,
                               input int v, input int s1, input int u1,
                               input int s2, input int u2, input int d,
                               input int w, input int c, input int t);
    @(posedge clk);
    #1;
    reset          = (rst != 0);
    bus.ie         = (ie != 0);
    bus.interrupt  = (intr != 0);
    bus.de_v       = (v != 0);
    bus.de_sr1     = RA_W'(s1);
    bus.de_sr1_use = (u1 != 0);
    bus.de_sr2     = RA_W'(s2);
    bus.de_sr2_use = (u2 != 0);
    bus.de_dr      = RA_W'(d);
    bus.de_dr_wen  = (w != 0);
    bus.de_ctrl    = (c != 0);
    bus.de_trap    = (t != 0);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reference model: issued instructions with issue cycle; age = now - issue.
  // Ages 1..N_BACK are in flight, age N_BACK is the final stage.
  typedef struct {
    int              cyc;
    logic [RA_W-1:0] dr;
    bit              wen;
    bit              ctrl;
    bit              trap;
    bit              alive;
  } rec_t;

  rec_t q[$];
  int   mcyc        = 0;
  bit   model_ready = 1'b0;
  bit   m_pend      = 1'b0;
  bit   m_take      = 1'b0;
  bit   m_served    = 1'b0;

  // Per-cycle compare against the model, then advance the model over the edge.
  always @(negedge clk) begin : compare
    int   age;
    int   e_occ, e_flush, e_dep, e_br, e_trap, e_block, e_issue, e_take;
    rec_t r;
    e_occ = 0; e_flush = 0; e_dep = 0; e_br = 0; e_trap = 0;
    foreach (q[k]) begin
      age = mcyc - q[k].cyc;
      if (q[k].alive && age >= 1 && age <= N_BACK) begin
        e_occ++;
        if (q[k].ctrl) e_br = 1;
        if (q[k].trap) e_trap = 1;
        if (age == N_BACK && q[k].trap) e_flush = 1;
        if (age <= CHK_AGE && q[k].wen) begin
          if (bus.de_sr1_use && bus.de_sr1 != 0 && q[k].dr == bus.de_sr1) e_dep = 1;
          if (bus.de_sr2_use && bus.de_sr2 != 0 && q[k].dr == bus.de_sr2) e_dep = 1;
        end
      end
    end
    if (!bus.de_v) e_dep = 0;
    if (bus.de_v && bus.de_ctrl) e_br = 1;
    if (bus.de_v && bus.de_trap) e_trap = 1;
    e_block = (bus.ie && (m_take || m_pend ||
               (!m_pend && !m_take && !m_served && bus.interrupt))) ? 1 : 0;
    e_issue = (bus.de_v && e_dep == 0 && e_flush == 0 && e_block == 0) ? 1 : 0;
    e_take  = m_take ? 1 : 0;

    if (model_ready) begin
      checkOutput("de_issue",     int'(bus.de_issue),     e_issue);
      checkOutput("v_dep_stall",  int'(bus.v_dep_stall),  e_dep);
      checkOutput("v_br_stall",   int'(bus.v_br_stall),   e_br);
      checkOutput("v_trap_stall", int'(bus.v_trap_stall), e_trap);
      checkOutput("flush",        int'(bus.flush),        e_flush);
      checkOutput("occ",          int'(bus.occ),          e_occ);
      checkOutput("int_taken",    int'(bus.int_taken),    e_take);
    end

    if (reset) begin
      q.delete();
      m_pend = 0; m_take = 0; m_served = 0;
      model_ready = 1'b1;
    end else begin
      if (e_flush != 0)
        foreach (q[k]) if (mcyc - q[k].cyc < N_BACK) q[k].alive = 1'b0;
      if (e_issue != 0) begin
        r.cyc = mcyc; r.dr = bus.de_dr; r.wen = bus.de_dr_wen;
        r.ctrl = bus.de_ctrl; r.trap = bus.de_trap; r.alive = 1'b1;
        q.push_back(r);
      end
      if (m_take) begin
        m_take = 0; m_served = 1;
      end else if (m_served) begin
        if (!bus.interrupt) m_served = 0;
      end else if (m_pend) begin
        if (!bus.ie) m_pend = 0;
        else if (e_occ == 0 && e_flush == 0) begin m_pend = 0; m_take = 1; end
      end else if (bus.interrupt && bus.ie) begin
        m_pend = 1;
      end
    end
    mcyc++;
    while (q.size() > 0 && mcyc - q[0].cyc > N_BACK) void'(q.pop_front());
  end

  // Directed scenarios followed by randomized traffic.
  initial begin : stim
    int stalls, pulses, viol;
    logic r_int, r_ie;
    bus.ie = 1'b1; bus.interrupt = 1'b1; bus.de_v = 1'b0;
    bus.de_sr1 = '0; bus.de_sr2 = '0; bus.de_sr1_use = 1'b0; bus.de_sr2_use = 1'b0;
    bus.de_dr = '0; bus.de_dr_wen = 1'b0; bus.de_ctrl = 1'b0; bus.de_trap = 1'b0;

    // Reset with the interrupt already requested.
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    checkOutput("rst_occ",        int'(bus.occ),          0);
    checkOutput("rst_int_taken",  int'(bus.int_taken),    0);
    checkOutput("rst_de_issue",   int'(bus.de_issue),     0);
    checkOutput("rst_dep",        int'(bus.v_dep_stall),  0);
    checkOutput("rst_br",         int'(bus.v_br_stall),   0);
    checkOutput("rst_trap",       int'(bus.v_trap_stall), 0);
    checkOutput("rst_flush",      int'(bus.flush),        0);
    idleCycles(6);

    // Back-to-back RAW dependency on x5.
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 5, 1, 0, 0);
    #2 checkOutput("b2b_producer_issue", int'(bus.de_issue), 1);
    stalls = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, 1, 0, 1, 5, 1, 0, 0, 9, 0, 0, 0);
      #2;
      if (bus.de_issue) break;
      stalls += int'(bus.v_dep_stall);
      if (i == 9) stalls = 99;
    end
    checkOutput("b2b_stall_cycles", stalls, CHK_AGE);
    idleCycles(4);

    // x0 destination and unused source never stall.
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 1, 3, 0, 9, 0, 0, 0);
    #2 checkOutput("x0_no_stall", int'(bus.v_dep_stall), 0);
    checkOutput("x0_issue", int'(bus.de_issue), 1);
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 7, 1, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 0, 7, 0, 9, 0, 0, 0);
    #2 checkOutput("unused_src_no_stall", int'(bus.v_dep_stall), 0);
    checkOutput("unused_src_issue", int'(bus.de_issue), 1);
    idleCycles(4);

    // Branch stall window t..t+3.
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
    #2 checkOutput("br_t0", int'(bus.v_br_stall), 1);
    for (int i = 1; i <= 4; i++) begin
      idleCycles(1);
      #2 checkOutput($sformatf("br_t%0d", i), int'(bus.v_br_stall), (i <= 3) ? 1 : 0);
    end
    idleCycles(2);

    // Trap flush with younger instructions behind it.
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    #2 checkOutput("trap_issue", int'(bus.de_issue), 1);
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    #2 checkOutput("trap_stall_t1", int'(bus.v_trap_stall), 1);
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 3, 0, 0, 0);
    #2 checkOutput("trap_flush_t3", int'(bus.flush), 1);
    checkOutput("trap_no_issue_t3", int'(bus.de_issue), 0);
    idleCycles(1);
    #2 checkOutput("trap_occ_t4", int'(bus.occ), 0);
    idleCycles(3);

    // Interrupt drain from two in-flight instructions.
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 checkOutput("int_occ2", int'(bus.occ), 2);
    checkOutput("int_block_issue", int'(bus.de_issue), 0);
    pulses = 0; viol = 0;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      if (pulses == 0 && bus.de_issue) viol++;
      if (bus.int_taken) begin
        pulses++;
        checkOutput("int_take_drained", int'(bus.occ), 0);
      end
    end
    checkOutput("int_no_issue_before_take", viol, 0);
    checkOutput("int_single_pulse", pulses, 1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2 if (bus.int_taken) pulses++;
    end
    checkOutput("int_second_request_pulse", pulses, 1);
    idleCycles(4);

    // Reset mid-flight with an interrupt pending.
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 2, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 0, 0, 0, 3, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 checkOutput("rstmid_occ3", int'(bus.occ), 3);
    applyStimulus(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 checkOutput("rstmid_occ0", int'(bus.occ), 0);
    checkOutput("rstmid_no_take", int'(bus.int_taken), 0);
    idleCycles(1);
    #2 checkOutput("rstmid_no_take_later", int'(bus.int_taken), 0);
    idleCycles(3);

    // Randomized traffic with small register space for frequent hits.
    r_int = 1'b0;
    r_ie  = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 29) == 0) r_int = ~r_int;
      if ($urandom_range(0, 39) == 0) r_ie  = ~r_ie;
      applyStimulus(($urandom_range(0, 199) == 0) ? 1 : 0, int'(r_ie), int'(r_int),
                    ($urandom_range(0, 3) != 0) ? 1 : 0,
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0) ? 1 : 0,
                    ($urandom_range(0, 19) == 0) ? 1 : 0);
    end
    idleCycles(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard and pipeline-control unit for the in-order RISC-V core, replacing the hand-wired per-stage stall/flush signals between decode and the back-end stages. Decode presents each candidate instruction's register usage and class. The unit tracks every in-flight instruction in a shadow shift register of depth `N_BACK`, one entry per back-end stage. From that state it produces dependency, branch and trap stalls, a single global flush, and a drained-pipeline interrupt-take pulse.

## Interface
- `N_BACK`, 3: number of back-end stages tracked after decode (EXE, MEM, WB); legal range 2–8.
- `RA_W`, 5: register-address width.
- `CLK` in 1: core clock.
- `RESET` in 1: synchronous, active-high reset.
- `DE_V` in 1: decode holds a valid instruction.
- `DE_SR1`, `DE_SR2` in `RA_W`: source registers.
- `DE_SR1_USE`, `DE_SR2_USE` in 1: the source is actually read.
- `DE_DR` in `RA_W`: destination register.
- `DE_DR_WEN` in 1: the instruction writes `DE_DR`.
- `DE_CTRL` in 1: branch/jump, i.e. it redirects the PC at the final stage.
- `DE_TRAP` in 1: ecall/mret/CSR context switch, i.e. it flushes at the final stage.
- `IE` in 1: interrupt-enable CSR bit.
- `INTERRUPT` in 1: level interrupt request.
- `DE_ISSUE` out 1: the decode instruction enters the back end this cycle.
- `V_DEP_STALL` out 1: RAW dependency stall.
- `V_BR_STALL` out 1: fetch must stall because a control transfer is unresolved.
- `V_TRAP_STALL` out 1: fetch must stall because a trap is in flight.
- `FLUSH` out 1: a trap instruction is in the final stage; invalidate fetch/decode.
- `INT_TAKEN` out 1: one-cycle pulse; the interrupt is taken this cycle.
- `OCC` out `$clog2(N_BACK+1)`: count of valid back-end entries.

## Operation
- Each entry holds {`v`, `dr`, `wen`, `ctrl`, `trap`}. Entry 0 is EXE and entry `N_BACK-1` is the final stage. The back end never stalls, so the array shifts every cycle.
- Entry 0 loads on issue: v = `DE_ISSUE`, and the other fields come from `DE_*`. If v = 0, the other fields are don't-care but must not create hazards.
- Hit rule: a source hits entry i when `v & wen & dr == src & src != 0 & SRx_USE`.
- `V_DEP_STALL` = `DE_V` and a hit on any source against any counted entry (see Configuration).
- `V_BR_STALL` = (`DE_V & DE_CTRL`) or any valid entry with `ctrl`.
- `V_TRAP_STALL` = (`DE_V & DE_TRAP`) or any valid entry with `trap`.
- `DE_ISSUE` = `DE_V & ~V_DEP_STALL & ~FLUSH & ~int_block`.
  - `int_block` = interrupt pending and `IE`.
  - Once an interrupt is pending, no new instruction issues; the pipeline drains.
- `FLUSH` = entry[`N_BACK-1`].v & entry[`N_BACK-1`].trap.
  - On the next edge, all entries other than the retiring one are invalidated.
  - Entry 0 loads v = 0.
- Interrupt state machine:
  - IDLE: go to PEND when `INTERRUPT & IE`.
  - PEND: go to TAKE when `OCC == 0`. Go back to IDLE if `IE` drops before that.
  - TAKE: `INT_TAKEN` = 1 for one cycle, then go to WAIT.
  - WAIT: go to IDLE when `INTERRUPT` deasserts. This gives one take per request level.
- `FLUSH` has priority over interrupt take in the same cycle. PEND holds and the take is retried once drained.

## Timing
- `V_DEP_STALL`, `V_BR_STALL`, `V_TRAP_STALL`, `DE_ISSUE` and `FLUSH` are combinational from state and decode inputs, valid in the same cycle.
- `INT_TAKEN` and `OCC` are registered or derived from registered state only.
- Latency:
  - An issued instruction is visible in entry 0 one cycle after issue.
  - It leaves the tracker `N_BACK` cycles after issue.
- Reset (synchronous): all `v` = 0, interrupt FSM = IDLE, `OCC` = 0.
  - With `DE_V` = 0, all outputs are 0.
  - `INT_TAKEN` = 0 in the first cycle after reset, even if `INTERRUPT` and `IE` are high.
- `RESET` asserted mid-flight discards all entries and any pending interrupt at that edge.
- Simultaneous retire of a producer and decode of its consumer is governed by Configuration.
- `OCC` saturates naturally at `N_BACK` and never wraps.

## Configuration
- `PIPE_HAZARD_WB_BYPASS_EN`:
  - Defined: the final-stage entry is excluded from the hit rule (the register file writes first, reads second). A consumer issues while its producer is in WB.
  - Undefined: all `N_BACK` entries are checked, and the consumer stalls until the producer has retired.

## Test plan
- Back-to-back dependency:
  - Stimulus: issue `DR`=5 with wen; next cycle decode SR1=5 USE=1.
  - Response: `V_DEP_STALL` = 1 for 2 cycles with bypass, 3 without (`N_BACK`=3); then `DE_ISSUE` = 1.
- x0 and unused sources:
  - Producer `DR`=0 wen=1 followed by SR1=0: no stall.
  - Producer `DR`=7 followed by SR2=7 USE=0: no stall.
- Branch:
  - Stimulus: `DE_CTRL` instruction issued at cycle t.
  - Response: `V_BR_STALL` = 1 from t through t+3, and 0 at t+4.
- Trap flush:
  - Stimulus: trap issued at t, with non-trap instructions attempted behind it.
  - Response: `FLUSH` = 1 at t+3 and `OCC` = 0 at t+4.
- Interrupt drain:
  - Stimulus: `OCC` = 2, then `INTERRUPT` = `IE` = 1.
  - Response: `DE_ISSUE` held at 0; `INT_TAKEN` pulses once when `OCC` reaches 0.
  - Holding `INTERRUPT` high yields no second pulse until it drops and rises again.
- Reset mid-flight:
  - Stimulus: 3 valid entries plus a pending interrupt; assert `RESET` for 1 cycle.
  - Response: `OCC` = 0 and no `INT_TAKEN` on the following cycle.
